// File: rtl/motion_bus_master_if.sv
// Command handshake and peripheral bus bundle for motion_bus_master.
// The master modport is the block's own view; slave is the host/peripheral side.
interface motion_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_rv1;
  logic [15:0] cmd_rv2;
  logic [15:0] cmd_rh1;
  logic [15:0] cmd_rh2;
  logic [1:0]  cmd_ss;
  logic        cs;
  logic [3:0]  addr;
  logic        wr;
  logic        rd;
  logic [15:0] d_out;
  logic [15:0] d_in;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  cmd_valid, cmd_rv1, cmd_rv2, cmd_rh1, cmd_rh2, cmd_ss, d_in,
    output cmd_ready, cs, addr, wr, rd, d_out, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_rv1, cmd_rv2, cmd_rh1, cmd_rh2, cmd_ss, d_in,
    input  cmd_ready, cs, addr, wr, rd, d_out, busy, done, err
  );
endinterface

// File: rtl/motion_bus_master.sv
// Replays one pan/tilt command as five single-cycle register writes (RV1, RV2, RH1, RH2, SS).
// Define MOTION_READBACK_EN to add a read-back check of every register after its write.
module motion_bus_master #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter logic [3:0]  ADDR_SS    = 4'h0,
  parameter logic [3:0]  ADDR_RV1   = 4'h2,
  parameter logic [3:0]  ADDR_RV2   = 4'h4,
  parameter logic [3:0]  ADDR_RH1   = 4'h6,
  parameter logic [3:0]  ADDR_RH2   = 4'h8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  motion_bus_master_if.master bus
);

  localparam int unsigned   GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    GAP,
`ifdef MOTION_READBACK_EN
    RD,
    CAP,
`endif
    DONE
  } state_e;

  state_e      state_q;
  logic [2:0]  idx_q, idx_d;
  logic [GW-1:0] gap_q;
  logic [15:0] rv1_q, rv2_q, rh1_q, rh2_q;
  logic [1:0]  ss_q;
  logic        cs_q, wr_q, ready_q, busy_q, done_q;
  logic [3:0]  addr_q;
  logic [15:0] dout_q;
  logic [19:0] next_reg;
  logic        last, post_gap, advance;

  // SS goes last so the mode/start bits only land once every setpoint is loaded.
  function automatic logic [19:0] sel_reg(input logic [2:0] idx,
                                          input logic [15:0] rv1, rv2, rh1, rh2,
                                          input logic [1:0] ss);
    case (idx)
      3'd0:    sel_reg = {ADDR_RV1, rv1};
      3'd1:    sel_reg = {ADDR_RV2, rv2};
      3'd2:    sel_reg = {ADDR_RH1, rh1};
      3'd3:    sel_reg = {ADDR_RH2, rh2};
      default: sel_reg = {ADDR_SS, 14'b0, ss};
    endcase
  endfunction

  assign idx_d    = idx_q + 3'd1;
  assign next_reg = sel_reg(idx_d, rv1_q, rv2_q, rh1_q, rh2_q, ss_q);
  assign last     = (idx_q == 3'd4);
  assign post_gap = ((state_q == WR) && (GAP_CYCLES == 0)) ||
                    ((state_q == GAP) && (gap_q == '0));

`ifdef MOTION_READBACK_EN
  logic rd_q, err_q, match;
  // d_out still holds the value just written, so it doubles as the expected read data.
  assign match   = last ? (bus.d_in[1:0] == dout_q[1:0]) : (bus.d_in == dout_q);
  assign advance = (state_q == CAP) && match;
`else
  assign advance = post_gap;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      rv1_q   <= '0;
      rv2_q   <= '0;
      rh1_q   <= '0;
      rh2_q   <= '0;
      ss_q    <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MOTION_READBACK_EN
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      cs_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef MOTION_READBACK_EN
      rd_q   <= 1'b0;
`endif
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (bus.cmd_valid) begin
            rv1_q   <= bus.cmd_rv1;
            rv2_q   <= bus.cmd_rv2;
            rh1_q   <= bus.cmd_rh1;
            rh2_q   <= bus.cmd_rh2;
            ss_q    <= bus.cmd_ss;
            idx_q   <= '0;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= ADDR_RV1;
            dout_q  <= bus.cmd_rv1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= WR;
`ifdef MOTION_READBACK_EN
            err_q   <= 1'b0;
`endif
          end
        end
        WR: begin
          if (GAP_CYCLES != 0) begin
            state_q <= GAP;
            gap_q   <= GAP_LOAD;
          end
        end
        GAP: gap_q <= gap_q - 1'b1;
`ifdef MOTION_READBACK_EN
        RD: state_q <= CAP;
        CAP: begin
          if (!match) begin
            err_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
`ifdef MOTION_READBACK_EN
      if (post_gap) begin
        state_q <= RD;
        cs_q    <= 1'b1;
        rd_q    <= 1'b1;
      end
`endif
      if (advance) begin
        if (last) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          idx_q            <= idx_d;
          state_q          <= WR;
          cs_q             <= 1'b1;
          wr_q             <= 1'b1;
          {addr_q, dout_q} <= next_reg;
        end
      end
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.cs        = cs_q;
  assign bus.wr        = wr_q;
  assign bus.addr      = addr_q;
  assign bus.d_out     = dout_q;
  assign bus.done      = done_q;
`ifdef MOTION_READBACK_EN
  assign bus.rd        = rd_q;
  assign bus.err       = err_q;
`else
  assign bus.rd        = 1'b0;
  assign bus.err       = 1'b0;
`endif

endmodule
